// File: rtl/fft_pkg.sv
// Shared types for the 16-point FFT output path:
// complex word, bin bit reversal, reorder read-side states.
package fft_pkg;

  localparam int NPT = 16;
  localparam int DW  = 64;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } rd_state_t;

  function automatic logic [3:0] bitrev4(
    input logic [3:0] a
  );
    return {a[0], a[1], a[2], a[3]};
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// 16-entry complex store: one row-wide write port (4 lanes),
// one asynchronous single-word read port.
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [1:0]  wrow,
  input  cplx_t [3:0] wdata,
  input  logic [3:0]  raddr,
  output cplx_t       rdata
);

  cplx_t mem [NPT];

  // Lane k of a beat lands at address {row, k}
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        mem[{wrow, 2'(k)}] <= wdata[k];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 16-pt FFT.
// Define FFT_REORDER_PINGPONG_EN for a second bank (overlap fill/drain).
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int NPT = 16,
  parameter int DW  = 64
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          in_ready,
  input  logic [DW-1:0] stage3_00,
  input  logic [DW-1:0] stage3_01,
  input  logic [DW-1:0] stage3_02,
  input  logic [DW-1:0] stage3_03,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] fft_d,
  output logic [3:0]    bin_idx,
  output logic          frame_done
);

`ifdef FFT_REORDER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  localparam int LAST = NPT - 1;

  logic [1:0]  g;
  logic [3:0]  r;
  logic        wr_bank;
  logic        rd_bank;
  logic [1:0]  full;
  rd_state_t   state;
  cplx_t [3:0] lanes;
  cplx_t       rd0;
  cplx_t       rdata;
  logic        wr_fire;
  logic        wr_last;
  logic        rd_fire;
  logic        rd_last;
  logic        nxt;
  logic        idle_go;
  logic        nxt_go;
  logic [1:0]  set_m;
  logic [1:0]  clr_m;

  assign lanes   = {stage3_03, stage3_02,
                    stage3_01, stage3_00};
  assign in_ready = !full[wr_bank];
  assign wr_fire = en && in_ready;
  assign wr_last = wr_fire && (g == 2'd3);
  assign rd_fire = out_valid && out_ready;
  assign rd_last = rd_fire && (r == LAST[3:0]);
  assign nxt     = rd_bank ^ PP;
  assign idle_go = full[rd_bank] ||
                   (wr_last && wr_bank == rd_bank);
  assign nxt_go  = PP && (full[nxt] ||
                   (wr_last && wr_bank == nxt));
  assign set_m   = wr_last ? (2'b01 << wr_bank) : 2'b00;
  assign clr_m   = rd_last ? (2'b01 << rd_bank) : 2'b00;

  fft_reorder_bank u_bank0 (
    .clk   (clk),
    .we    (wr_fire && !wr_bank),
    .wrow  (g),
    .wdata (lanes),
    .raddr (bitrev4(r)),
    .rdata (rd0)
  );

`ifdef FFT_REORDER_PINGPONG_EN
  cplx_t rd1;

  fft_reorder_bank u_bank1 (
    .clk   (clk),
    .we    (wr_fire && wr_bank),
    .wrow  (g),
    .wdata (lanes),
    .raddr (bitrev4(r)),
    .rdata (rd1)
  );

  assign rdata = rd_bank ? rd1 : rd0;
`else
  assign rdata = rd0;
`endif

  assign fft_d   = out_valid ? rdata : '0;
  assign bin_idx = r;

  // Write side: beat counter, bank fill flags, write bank select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g       <= 2'd0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= (full | set_m) & ~clr_m;
      if (wr_fire) begin
        g <= g + 2'd1;
      end
      if (wr_last) begin
        wr_bank <= wr_bank ^ PP;
      end
    end
  end

  // Read side: drain a full bank in natural bin order
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      r          <= 4'd0;
      rd_bank    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (idle_go) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
            r         <= 4'd0;
          end
        end
        DRAIN: begin
          if (rd_last) begin
            frame_done <= 1'b1;
            rd_bank    <= nxt;
            r          <= 4'd0;
            if (!nxt_go) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end else if (rd_fire) begin
            r <= r + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder; covers the
// single-bank or ping-pong build, whichever is compiled.
module tb_fft_output_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_ready;
  logic [63:0] stage3_00;
  logic [63:0] stage3_01;
  logic [63:0] stage3_02;
  logic [63:0] stage3_03;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fft_d;
  logic [3:0]  bin_idx;
  logic        frame_done;

  int n_chk = 0;
  int n_fail = 0;

  int brv [16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                   1, 9, 5, 13, 3, 11, 7, 15};

  fft_output_reorder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_ready   (in_ready),
    .stage3_00  (stage3_00),
    .stage3_01  (stage3_01),
    .stage3_02  (stage3_02),
    .stage3_03  (stage3_03),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fft_d      (fft_d),
    .bin_idx    (bin_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int v);
    return {32'(v), 32'(v)};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int base, input int g);
    stage3_00 = mk(base + 4*g + 0);
    stage3_01 = mk(base + 4*g + 1);
    stage3_02 = mk(base + 4*g + 2);
    stage3_03 = mk(base + 4*g + 3);
  endtask

  task automatic load_frame(input int base);
    for (int g = 0; g < 4; g++) begin
      en = 1'b1;
      set_beat(base, g);
      chk("load_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    en = 1'b0;
  endtask

  task automatic chk_bin(input int base, input int i);
    chk("bin_valid", 64'(out_valid), 64'd1);
    chk("bin_idx", 64'(bin_idx), 64'(i));
    chk("bin_data", fft_d, mk(base + brv[i]));
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    out_ready = 1'b0;
    set_beat(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fft_d", fft_d, 64'd0);
    chk("rst_bin_idx", 64'(bin_idx), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);

`ifndef FFT_REORDER_PINGPONG_EN
    // Frame A: bit reversal, blocked input during drain
    load_frame(0);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      en = 1'b1;
      set_beat(12'hbad, i % 4);
      chk_bin(0, i);
      chk("drain_in_ready", 64'(in_ready), 64'd0);
      chk("drain_fdone", 64'(frame_done), 64'd0);
      tick();
    end
    en = 1'b0;
    chk("a_frame_done", 64'(frame_done), 64'd1);
    chk("a_out_valid", 64'(out_valid), 64'd0);
    chk("a_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("a_fdone_pulse", 64'(frame_done), 64'd0);

    // Frame B: backpressure at bin 5
    load_frame(100);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk_bin(100, 5);
          tick();
        end
        out_ready = 1'b1;
      end
      chk_bin(100, i);
      tick();
    end
    chk("b_frame_done", 64'(frame_done), 64'd1);
    chk("b_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-drain, then partial frame discarded by reset
    load_frame(200);
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_fft_d", fft_d, 64'd0);
    chk("mid_bin_idx", 64'(bin_idx), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    en = 1'b1;
    set_beat(12'hbad, 0);
    tick();
    tick();
    en = 1'b0;
    #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    load_frame(300);
    for (int i = 0; i < 16; i++) begin
      chk_bin(300, i);
      tick();
    end
    chk("d_frame_done", 64'(frame_done), 64'd1);
`else
    // Two frames back-to-back with out_ready held high
    out_ready = 1'b1;
    for (int c = 0; c < 37; c++) begin
      en = (c < 8);
      set_beat(c < 4 ? 0 : 16, c % 4);
      if (c < 8)
        chk("pp_in_ready", 64'(in_ready), 64'd1);
      if (c >= 4 && c < 36)
        chk_bin(c < 20 ? 0 : 16, (c - 4) % 16);
      chk("pp_fdone", 64'(frame_done),
          64'(c == 20 || c == 36));
      if (c == 36)
        chk("pp_end_valid", 64'(out_valid), 64'd0);
      tick();
    end
    en = 1'b0;

    // Both banks full under backpressure
    out_ready = 1'b0;
    load_frame(32);
    load_frame(48);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    en = 1'b1;
    set_beat(12'hbad, 0);
    tick();
    en = 1'b0;
    chk("beat9_in_ready", 64'(in_ready), 64'd0);
    chk_bin(32, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_bin(32, i);
      chk("c_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    chk("c_frame_done", 64'(frame_done), 64'd1);
    chk("c_in_ready_up", 64'(in_ready), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk_bin(48, i);
      tick();
    end
    chk("d_frame_done", 64'(frame_done), 64'd1);
    chk("d_out_valid", 64'(out_valid), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
